// File: rtl/dense_argmax_pkg.sv
// Shared types and defaults for the dense_argmax classifier head.
package dense_argmax_pkg;

    localparam int FEATURE_MAP_RESOLUTION   = 8;
    localparam int DENSE_ARGMAX_NUM_NEURONS = 40;

    // Index width never collapses to zero, even for a single-neuron layer.
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    localparam int DENSE_ARGMAX_IDX_WIDTH = idx_width(DENSE_ARGMAX_NUM_NEURONS);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SCAN = 2'd1,
        DONE = 2'd2
    } argmax_state_t;

endpackage

// File: rtl/dense_argmax_cmp_stage.sv
// Signed compare/select of the running best against one candidate logit.
module dense_argmax_cmp_stage
    import dense_argmax_pkg::*;
#(
    parameter int DATA_WIDTH = FEATURE_MAP_RESOLUTION,
    parameter int IDX_WIDTH  = DENSE_ARGMAX_IDX_WIDTH
) (
    input  logic [DATA_WIDTH-1:0] best_val,
    input  logic [IDX_WIDTH-1:0]  best_idx,
    input  logic [DATA_WIDTH-1:0] cand_val,
    input  logic [IDX_WIDTH-1:0]  cand_idx,
    output logic [DATA_WIDTH-1:0] sel_val,
    output logic [IDX_WIDTH-1:0]  sel_idx
);

    // NOTE: defaults assigned first so every path drives both outputs and no latch is inferred.
    always_comb begin
        sel_val = best_val;
        sel_idx = best_idx;
        // Strictly greater only: candidates arrive in ascending index order, so ties keep the lower index.
        if ($signed(cand_val) > $signed(best_val)) begin
            sel_val = cand_val;
            sel_idx = cand_idx;
        end
    end

endmodule

// File: rtl/dense_argmax.sv
// Sequential argmax over one Dense output vector; optional reject flag under ARGMAX_CONF_THRESH_EN.
module dense_argmax
    import dense_argmax_pkg::*;
#(
    parameter int NUM_NEURONS = DENSE_ARGMAX_NUM_NEURONS,
    parameter int DATA_WIDTH  = FEATURE_MAP_RESOLUTION,
    parameter int IDX_WIDTH   = idx_width(NUM_NEURONS)
`ifdef ARGMAX_CONF_THRESH_EN
    ,parameter logic signed [DATA_WIDTH-1:0] CONF_THRESHOLD = '0
`endif
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  argmax_valid_i,
    input  logic [DATA_WIDTH-1:0] argmax_data_i [0:NUM_NEURONS-1],
    output logic                  argmax_ready_o,
    output logic                  argmax_valid_o,
    output logic [IDX_WIDTH-1:0]  argmax_class_o,
    output logic [DATA_WIDTH-1:0] argmax_score_o,
    input  logic                  argmax_ready_i
`ifdef ARGMAX_CONF_THRESH_EN
    ,output logic                 argmax_reject_o
`endif
);

    localparam logic [IDX_WIDTH-1:0] LAST_IDX = IDX_WIDTH'(NUM_NEURONS - 1);

    argmax_state_t         state_q;
    logic [DATA_WIDTH-1:0] buf_q [0:NUM_NEURONS-1];
    logic [IDX_WIDTH-1:0]  ptr_q;
    logic [IDX_WIDTH-1:0]  best_idx_q;
    logic [DATA_WIDTH-1:0] best_val_q;
    logic [IDX_WIDTH-1:0]  next_idx;
    logic [DATA_WIDTH-1:0] next_val;

    dense_argmax_cmp_stage #(
        .DATA_WIDTH (DATA_WIDTH),
        .IDX_WIDTH  (IDX_WIDTH)
    ) u_cmp (
        .best_val (best_val_q),
        .best_idx (best_idx_q),
        .cand_val (buf_q[ptr_q]),
        .cand_idx (ptr_q),
        .sel_val  (next_val),
        .sel_idx  (next_idx)
    );

    // NOTE: state and outputs update with non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q        <= IDLE;
            ptr_q          <= '0;
            best_idx_q     <= '0;
            best_val_q     <= '0;
            argmax_ready_o <= 1'b1;
            argmax_valid_o <= 1'b0;
            argmax_class_o <= '0;
            argmax_score_o <= '0;
`ifdef ARGMAX_CONF_THRESH_EN
            argmax_reject_o <= 1'b0;
`endif
            // NOTE: the vector buffer is cleared on reset so a discarded scan leaves no stale logits behind.
            for (int i = 0; i < NUM_NEURONS; i++) begin
                buf_q[i] <= '0;
            end
        end else begin
            case (state_q)
                IDLE: begin
                    if (argmax_valid_i && argmax_ready_o) begin
                        for (int i = 0; i < NUM_NEURONS; i++) begin
                            buf_q[i] <= argmax_data_i[i];
                        end
                        best_val_q     <= argmax_data_i[0];
                        best_idx_q     <= '0;
                        ptr_q          <= IDX_WIDTH'(1);
                        argmax_ready_o <= 1'b0;
                        if (NUM_NEURONS == 1) begin
                            state_q        <= DONE;
                            argmax_valid_o <= 1'b1;
                            argmax_class_o <= '0;
                            argmax_score_o <= argmax_data_i[0];
`ifdef ARGMAX_CONF_THRESH_EN
                            argmax_reject_o <= $signed(argmax_data_i[0]) < CONF_THRESHOLD;
`endif
                        end else begin
                            state_q <= SCAN;
                        end
                    end
                end
                SCAN: begin
                    best_val_q <= next_val;
                    best_idx_q <= next_idx;
                    if (ptr_q == LAST_IDX) begin
                        state_q        <= DONE;
                        argmax_valid_o <= 1'b1;
                        argmax_class_o <= next_idx;
                        argmax_score_o <= next_val;
`ifdef ARGMAX_CONF_THRESH_EN
                        argmax_reject_o <= $signed(next_val) < CONF_THRESHOLD;
`endif
                    end else begin
                        ptr_q <= ptr_q + IDX_WIDTH'(1);
                    end
                end
                DONE: begin
                    // Result stays frozen until the consumer takes it; only then is a new vector accepted.
                    if (argmax_ready_i) begin
                        state_q        <= IDLE;
                        argmax_valid_o <= 1'b0;
                        argmax_ready_o <= 1'b1;
`ifdef ARGMAX_CONF_THRESH_EN
                        argmax_reject_o <= 1'b0;
`endif
                    end
                end
                default: begin
                    state_q        <= IDLE;
                    argmax_ready_o <= 1'b1;
                    argmax_valid_o <= 1'b0;
                end
            endcase
        end
    end

endmodule
